pe_filter_rx: RTL and testbench
===============================

// Module: pe_filter_rx
// PURPOSE
//  PE-side receiver for filter-load packets issued by the filter memory over the NoC.
//  - Decodes 32-bit packets addressed to this PE and collects one filter row (WIDTH_F weights) in a local buffer.
//  - Once the row is complete, streams it to the PE MAC datapath NUM_PASS times, then re-arms for the next row.
// PARAMETERS
//  WIDTH_DATA  13  weight width (bits)
//  WIDTH_F     5   weights per filter row; valid range 1..255
//  NUM_PASS    3   times the row is streamed to the MAC per load; valid range >=1
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous assert, active-low reset
//  my_addr    in   8           this PE's NoC address; quasi-static
//  flush      in   1           sync pulse: discard partial row/stream, return to LOAD
//  in_valid   in   1           packet valid
//  in_ready   out  1           packet accept
//  in_pkt     in   32          {rsvd[31], type[30:29], dst[28:21], idx[20:13], data[12:0]}
//  out_valid  out  1           weight valid to MAC
//  out_ready  in   1           MAC accept
//  out_data   out  WIDTH_DATA  weight value
//  out_idx    out  8           weight column index
//  out_last   out  1           high with idx WIDTH_F-1 of the final pass
//  row_loaded out  1           high while state==STREAM
//  err        out  1           sticky: any dropped packet; cleared only by reset
//  drop_cnt   out  8           dropped-packet count; saturates at 255
// BEHAVIOUR
//  Handshakes and reset
//  - Transfer on valid&&ready at a clk edge.
//  - out_valid/out_data/out_idx/out_last hold stable until accepted.
//  - Reset: state=LOAD, row buffer and mask cleared, all outputs 0 except in_ready=1.
//  FSM
//  - LOAD: in_ready=1, out_valid=0.
//  - STREAM: in_ready=0, out_valid=1.
//  Packet acceptance
//  - A packet is kept iff rsvd==0, type==2'b00 (FILTER), dst==my_addr and idx<WIDTH_F.
//  - Kept packet: buf[idx]<=data, mask[idx]<=1.
//  - Repeated idx overwrites the stored value and is not counted twice.
//  - Any other accepted packet is dropped: buffer/mask unchanged, err<=1, drop_cnt+1 (saturating).
//  LOAD->STREAM
//  - On the edge where mask becomes all-ones; the completing write is included in the row.
//  - out_valid=1 with idx 0 in the next cycle, so latency = 1 clk from the last packet to the first weight.
//  STREAM
//  - Counters: col (0..WIDTH_F-1), pass (0..NUM_PASS-1).
//  - On each out accept: col++.
//  - At col==WIDTH_F-1: col<=0 and pass++.
//  - On accept with out_last: mask<=0, pass<=0, state<=LOAD.
//  - in_ready rises the next cycle, with no bubble beyond that.
//  - Buffer contents persist after the stream; only the mask is cleared.
//  flush
//  - Highest priority over all other actions in that cycle.
//  - Clears mask, col and pass; state<=LOAD.
//  - A packet presented in the same cycle is not accepted, because in_ready is forced 0 during flush.
//  - err and drop_cnt are not affected by flush.
//  Async reset mid-stream
//  - Immediately drops out_valid.
//  - No partial row survives reset.
//  Widths
//  - idx compare is done at 8 bits.
//  - col/pass are $clog2 sized, with a minimum of 1 bit.
// STRUCTURE
//  Shared package noc_pkg
//  - Typedef noc_pkt_t: packed struct with fields rsvd, dtype[1:0], dst[7:0], idx[7:0], data[12:0].
//  - Constants PKT_TYPE_FILTER=2'b00, PKT_TYPE_IFMAP=2'b01, PKT_TYPE_PSUM=2'b10.
//  - The filter memory transmitter uses the same package.
//  Sub-modules and logic split
//  - One sub-module, noc_pkt_decode: combinational unpack plus a keep/drop verdict (match, idx range).
//  - FSM, counters and buffer live in pe_filter_rx.
// TESTING
//  T1 Basic load
//   - Stimulus: my_addr=3; send idx 0..4 to dst=3, data 10..14, out_ready=1.
//   - Expect: 15 weights streamed, order 10..14 repeated x3; out_last only on the 15th; in_ready returns high.
//  T2 Out-of-order + duplicate
//   - Stimulus: send idx 4,2,2(data=99),0,1,3.
//   - Expect: stream shows buf[2]=99; STREAM entered only after idx 3.
//  T3 Drops
//   - Stimulus: send dst=5, type=01, rsvd=1, idx=7.
//   - Expect: buffer untouched, err=1, drop_cnt=4.
//   - Then a 5-packet valid row streams normally.
//  T4 Backpressure
//   - Stimulus: during STREAM, toggle out_ready randomly for 40 cycles.
//   - Expect: no weight lost or duplicated; outputs stable while stalled; in_valid ignored (in_ready=0).
//  T5 Flush
//   - Stimulus: pulse flush after 3 packets, then 5 more packets.
//   - Expect: stream contains only the later 5 values.
//   - Stimulus: pulse flush mid-STREAM.
//   - Expect: out_valid=0 next cycle and state LOAD.
//  T6 Reset
//   - Stimulus: assert rst_n=0 asynchronously mid-STREAM.
//   - Expect: out_valid=0 immediately, err=0, drop_cnt=0, in_ready=1 after release.
//   - Stimulus: 255+2 dropped packets.
//   - Expect: drop_cnt saturates at 255.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions used by the filter-memory transmitter and the PE receivers.
package noc_pkg;

    localparam int PKT_DATA_W = 13;

    localparam logic [1:0] PKT_TYPE_FILTER = 2'b00;
    localparam logic [1:0] PKT_TYPE_IFMAP  = 2'b01;
    localparam logic [1:0] PKT_TYPE_PSUM   = 2'b10;

    typedef struct packed {
        logic                  rsvd;
        logic [1:0]            dtype;
        logic [7:0]            dst;
        logic [7:0]            idx;
        logic [PKT_DATA_W-1:0] data;
    } noc_pkt_t;

    typedef enum logic {
        RX_LOAD,
        RX_STREAM
    } rx_state_t;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_filter_rx_if.sv
// Packet-in / weight-out handshake bundle between the NoC, the filter receiver and the MAC.
interface pe_filter_rx_if #(
    parameter int WIDTH_DATA = 13
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_pkt;

    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH_DATA-1:0] out_data;
    logic [7:0]            out_idx;
    logic                  out_last;

    modport master (
        output in_valid, in_pkt, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_pkt, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/noc_pkt_decode.sv
// Combinational unpack of a NoC packet plus the keep/drop verdict for this PE's filter row.
module noc_pkt_decode
    import noc_pkg::*;
#(
    parameter int WIDTH_F = 5
) (
    input  logic [31:0]           raw,
    input  logic [7:0]            my_addr,
    output logic [7:0]            idx,
    output logic [PKT_DATA_W-1:0] data,
    output logic                  keep
);
    localparam logic [7:0] IDX_LIMIT = 8'(WIDTH_F);

    noc_pkt_t pkt;

    assign pkt  = noc_pkt_t'(raw);
    assign idx  = pkt.idx;
    assign data = pkt.data;

    always_comb begin
        // NOTE: default first so every path assigns keep; a missing else would infer a latch.
        keep = 1'b0;
        if (!pkt.rsvd && pkt.dtype == PKT_TYPE_FILTER &&
            pkt.dst == my_addr && pkt.idx < IDX_LIMIT)
            keep = 1'b1;
    end
endmodule

// File: rtl/pe_filter_rx.sv
// PE filter-row receiver: collects WIDTH_F weights from NoC packets, then streams the row
// to the MAC NUM_PASS times before re-arming for the next row.
module pe_filter_rx
    import noc_pkg::*;
#(
    parameter int WIDTH_DATA = 13,
    parameter int WIDTH_F    = 5,
    parameter int NUM_PASS   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          my_addr,
    input  logic                flush,
    pe_filter_rx_if.slave       bus,
    output logic                row_loaded,
    output logic                err,
    output logic [7:0]          drop_cnt
);
    localparam int COL_W  = cnt_width(WIDTH_F);
    localparam int PASS_W = cnt_width(NUM_PASS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH_F - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASS - 1);

    rx_state_t             state;
    logic [WIDTH_DATA-1:0] row_buf [WIDTH_F];
    logic [WIDTH_F-1:0]    mask;
    logic [WIDTH_F-1:0]    mask_set;
    logic [COL_W-1:0]      col;
    logic [PASS_W-1:0]     pass;

    logic [7:0]            pkt_idx;
    logic [PKT_DATA_W-1:0] pkt_data;
    logic                  keep;
    logic                  in_fire;
    logic                  out_fire;
    logic                  at_last;

    noc_pkt_decode #(.WIDTH_F(WIDTH_F)) u_decode (
        .raw     (bus.in_pkt),
        .my_addr (my_addr),
        .idx     (pkt_idx),
        .data    (pkt_data),
        .keep    (keep)
    );

    // flush masks in_ready so a packet offered alongside it is never consumed.
    assign bus.in_ready  = (state == RX_LOAD) && !flush;
    assign in_fire       = bus.in_valid && bus.in_ready;

    assign at_last       = (col == COL_LAST) && (pass == PASS_LAST);
    assign bus.out_valid = (state == RX_STREAM);
    assign out_fire      = bus.out_valid && bus.out_ready;
    assign bus.out_data  = row_buf[col];
    assign bus.out_idx   = 8'(col);
    assign bus.out_last  = bus.out_valid && at_last;
    assign row_loaded    = (state == RX_STREAM);

    // Only meaningful when keep is set, which already bounds pkt_idx below WIDTH_F.
    assign mask_set = mask | (WIDTH_F'(1) << pkt_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
            state    <= RX_LOAD;
            mask     <= '0;
            col      <= '0;
            pass     <= '0;
            err      <= 1'b0;
            drop_cnt <= '0;
            // NOTE: the row buffer is reset deliberately so no stale weights survive reset.
            for (int i = 0; i < WIDTH_F; i++)
                row_buf[i] <= '0;
        end else if (flush) begin
            mask  <= '0;
            col   <= '0;
            pass  <= '0;
            state <= RX_LOAD;
        end else begin
            case (state)
                RX_LOAD: begin
                    if (in_fire) begin
                        if (keep) begin
                            row_buf[pkt_idx[COL_W-1:0]] <= WIDTH_DATA'(pkt_data);
                            mask <= mask_set;
                            if (&mask_set) begin
                                state <= RX_STREAM;
                                col   <= '0;
                                pass  <= '0;
                            end
                        end else begin
                            err <= 1'b1;
                            if (drop_cnt != 8'hFF)
                                drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                end
                RX_STREAM: begin
                    if (out_fire) begin
                        if (at_last) begin
                            mask  <= '0;
                            col   <= '0;
                            pass  <= '0;
                            state <= RX_LOAD;
                        end else if (col == COL_LAST) begin
                            col  <= '0;
                            pass <= pass + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= RX_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_filter_rx.sv
// Directed + randomized bench for pe_filter_rx against a row/queue reference model.
module tb_pe_filter_rx;

    localparam int WD = 13;
    localparam int WF = 5;
    localparam int NP = 3;

    typedef struct {
        logic [WD-1:0] data;
        logic [7:0]    idx;
        logic          last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] my_addr;
    logic       flush;
    logic       row_loaded;
    logic       err;
    logic [7:0] drop_cnt;

    pe_filter_rx_if #(.WIDTH_DATA(WD)) bus ();

    pe_filter_rx #(.WIDTH_DATA(WD), .WIDTH_F(WF), .NUM_PASS(NP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .my_addr    (my_addr),
        .flush      (flush),
        .bus        (bus),
        .row_loaded (row_loaded),
        .err        (err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [WD-1:0] mbuf [WF];
    bit            mset [WF];
    bit            mstream;
    bit            merr;
    int            mdrop;
    exp_t          q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit r, input logic [1:0] t, input logic [7:0] d,
                                       input logic [7:0] i, input logic [12:0] v);
        return {r, t, d, i, v};
    endfunction

    task automatic model_reset();
        foreach (mbuf[i]) mbuf[i] = '0;
        foreach (mset[i]) mset[i] = 1'b0;
        mstream = 1'b0;
        merr    = 1'b0;
        mdrop   = 0;
        q.delete();
    endtask

    // Spec-level view: a packet either lands in the row or is counted as a drop.
    task automatic model_accept(input logic [31:0] pkt);
        bit full;
        exp_t e;
        if (pkt[31] == 1'b0 && pkt[30:29] == 2'b00 && pkt[28:21] == my_addr &&
            int'(pkt[20:13]) < WF) begin
            mbuf[pkt[20:13]] = pkt[12:0];
            mset[pkt[20:13]] = 1'b1;
            full = 1'b1;
            foreach (mset[i]) if (!mset[i]) full = 1'b0;
            if (full) begin
                mstream = 1'b1;
                for (int p = 0; p < NP; p++)
                    for (int c = 0; c < WF; c++) begin
                        e.data = mbuf[c];
                        e.idx  = 8'(c);
                        e.last = (p == NP - 1) && (c == WF - 1);
                        q.push_back(e);
                    end
            end
        end else begin
            merr = 1'b1;
            if (mdrop < 255) mdrop++;
        end
    endtask

    task automatic send(input logic [31:0] pkt);
        bus.in_valid = 1'b1;
        bus.in_pkt   = pkt;
        #1;
        check("in_ready_load", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model_accept(pkt);
        check("out_valid_after_pkt", 32'(bus.out_valid), 32'(mstream));
        check("err", 32'(err), 32'(merr));
        check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    endtask

    task automatic load_row(input int seed_base);
        for (int i = 0; i < WF; i++)
            send(mk(1'b0, 2'b00, my_addr, 8'(i), 13'($urandom_range(0, 8191) ^ seed_base)));
    endtask

    // Accept up to n_accept weights, comparing each offered weight with the model queue.
    task automatic drain(input int n_accept, input bit rnd);
        int            acc = 0;
        int            cyc = 0;
        bit            stalled = 1'b0;
        logic [WD-1:0] pd = '0;
        logic [7:0]    pi = '0;
        logic          pl = 1'b0;
        while (acc < n_accept && q.size() > 0) begin
            if (cyc >= 400) begin
                n_checks++;
                n_err++;
                $error("FAIL drain_timeout: observed %0d weights left expected 0", q.size());
                break;
            end
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_pkt    = $urandom;
            #1;
            check("in_ready_stream", 32'(bus.in_ready), 32'd0);
            check("out_valid_stream", 32'(bus.out_valid), 32'd1);
            if (stalled) begin
                check("stall_data", 32'(bus.out_data), 32'(pd));
                check("stall_idx", 32'(bus.out_idx), 32'(pi));
                check("stall_last", 32'(bus.out_last), 32'(pl));
            end
            check("out_data", 32'(bus.out_data), 32'(q[0].data));
            check("out_idx", 32'(bus.out_idx), 32'(q[0].idx));
            check("out_last", 32'(bus.out_last), 32'(q[0].last));
            pd = bus.out_data;
            pi = bus.out_idx;
            pl = bus.out_last;
            stalled = !bus.out_ready;
            if (bus.out_ready) begin
                void'(q.pop_front());
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        if (q.size() == 0) begin
            mstream = 1'b0;
            foreach (mset[i]) mset[i] = 1'b0;
            #1;
            check("out_valid_rearm", 32'(bus.out_valid), 32'd0);
            check("in_ready_rearm", 32'(bus.in_ready), 32'd1);
            check("row_loaded_rearm", 32'(row_loaded), 32'd0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        my_addr       = 8'd3;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pkt    = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_row_loaded", 32'(row_loaded), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: in-order row 10..14, streamed three times.
        for (int i = 0; i < WF; i++)
            send(mk(1'b0, 2'b00, 8'd3, 8'(i), 13'(10 + i)));
        check("t1_first_weight", 32'(bus.out_data), 32'd10);
        drain(1000, 1'b0);

        // T2: out-of-order with a duplicate; row completes only on idx 3.
        send(mk(1'b0, 2'b00, 8'd3, 8'd4, 13'd44));
        send(mk(1'b0, 2'b00, 8'd3, 8'd2, 13'd22));
        send(mk(1'b0, 2'b00, 8'd3, 8'd2, 13'd99));
        send(mk(1'b0, 2'b00, 8'd3, 8'd0, 13'd5));
        send(mk(1'b0, 2'b00, 8'd3, 8'd1, 13'd6));
        check("t2_not_streaming", 32'(row_loaded), 32'd0);
        send(mk(1'b0, 2'b00, 8'd3, 8'd3, 13'd7));
        check("t2_streaming", 32'(row_loaded), 32'd1);
        drain(1000, 1'b0);

        // T3: four kinds of dropped packet, then a normal row.
        send(mk(1'b0, 2'b00, 8'd5, 8'd0, 13'd1));
        send(mk(1'b0, 2'b01, 8'd3, 8'd1, 13'd2));
        send(mk(1'b1, 2'b00, 8'd3, 8'd2, 13'd3));
        send(mk(1'b0, 2'b00, 8'd3, 8'd7, 13'd4));
        check("t3_drop_cnt", 32'(drop_cnt), 32'd4);
        check("t3_err", 32'(err), 32'd1);
        load_row(0);
        drain(1000, 1'b0);

        // T4: random backpressure with stray in_valid during the stream.
        load_row(16'h1234);
        drain(1000, 1'b1);
        load_row(16'h0f0f);
        drain(1000, 1'b1);

        // T5a: flush after three packets discards them and blocks a coincident packet.
        send(mk(1'b0, 2'b00, 8'd3, 8'd0, 13'd100));
        send(mk(1'b0, 2'b00, 8'd3, 8'd1, 13'd101));
        send(mk(1'b0, 2'b00, 8'd3, 8'd2, 13'd102));
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pkt   = mk(1'b0, 2'b00, 8'd3, 8'd3, 13'd103);
        #1;
        check("t5_in_ready_flush", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        foreach (mset[i]) mset[i] = 1'b0;
        send(mk(1'b0, 2'b00, 8'd3, 8'd3, 13'd203));
        send(mk(1'b0, 2'b00, 8'd3, 8'd4, 13'd204));
        send(mk(1'b0, 2'b00, 8'd3, 8'd0, 13'd200));
        send(mk(1'b0, 2'b00, 8'd3, 8'd1, 13'd201));
        send(mk(1'b0, 2'b00, 8'd3, 8'd2, 13'd202));
        drain(1000, 1'b0);

        // T5b: flush mid-stream returns to LOAD with an empty mask.
        load_row(16'h0abc);
        drain(4, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("t5_flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_flush_row_loaded", 32'(row_loaded), 32'd0);
        check("t5_flush_in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        mstream = 1'b0;
        foreach (mset[i]) mset[i] = 1'b0;
        load_row(16'h0555);
        drain(1000, 1'b0);

        // T6: asynchronous reset in the middle of a stream.
        load_row(16'h0333);
        drain(7, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_out_data", 32'(bus.out_data), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        check("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_in_ready_release", 32'(bus.in_ready), 32'd1);
        load_row(16'h0777);
        drain(1000, 1'b0);

        // T6b: drop counter saturates at 255.
        for (int i = 0; i < 257; i++)
            send(mk(1'b0, 2'b00, 8'd9, 8'd0, 13'(i)));
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);
        check("t6_err_sat", 32'(err), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
